// File: rtl/div_frec_multi_pkg.sv
// Shared constants and types for the multi-channel frequency divider.
//   CLK_HZ             : system clock frequency (Nexys 4 board clock)
//   DIV_1HZ/10HZ/1KHZ  : divisors producing 1 Hz, 10 Hz and 1 kHz ticks
//   CNT_W_DEF          : default divisor/counter width, wide enough for DIV_1HZ
//   LD_CH_W            : width of the load channel index
//   ch_op_e            : per-channel action selected on each clock edge
package div_frec_multi_pkg;

  localparam int unsigned CLK_HZ    = 100_000_000;
  localparam int unsigned DIV_1HZ   = CLK_HZ;
  localparam int unsigned DIV_10HZ  = CLK_HZ / 10;
  localparam int unsigned DIV_1KHZ  = CLK_HZ / 1000;
  localparam int unsigned CNT_W_DEF = 27;
  localparam int unsigned LD_CH_W   = 3;

  typedef enum logic [1:0] {
    CH_HOLD,
    CH_COUNT,
    CH_RESTART
  } ch_op_e;

endpackage

// File: rtl/div_frec_ch.sv
// One divider channel: programmable divisor, phase counter, tick strobe and
// near-50% square wave.
//   clk_i      : system clock
//   rst_i      : synchronous active-high reset (divisor returns to DIV_RST)
//   run_i      : count enable for this edge
//   clr_i      : restart the period (cnt to 0), divisor kept
//   ld_i       : load ld_val_i as the new divisor and restart the period
//   ld_val_i   : divisor to load; 0 behaves as 1
//   tick_o     : one-cycle strobe once every d enabled cycles
//   clk_out_o  : high for floor(d/2), low for ceil(d/2) enabled cycles
module div_frec_ch
  import div_frec_multi_pkg::*;
#(
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_1HZ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  output logic             tick_o,
  output logic             clk_out_o
);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic [CNT_W-1:0] d_eff;
  logic [CNT_W-1:0] half;
  ch_op_e           op;

  always_comb begin
    op = CH_HOLD;
    if (ld_i || clr_i) begin
      op = CH_RESTART;
    end else if (run_i) begin
      op = CH_COUNT;
    end

    // On a load the restart phase is derived from the new divisor.
    div_d = ld_i ? ld_val_i : div_q;
    d_eff = (div_d == '0) ? CNT_W'(1) : div_d;
    half  = d_eff >> 1;

    cnt_d  = cnt_q;
    tick_d = 1'b0;
    clk_d  = clk_q;

    case (op)
      CH_RESTART: begin
        cnt_d = '0;
        clk_d = (half != '0);
      end
      CH_COUNT: begin
        if (cnt_q == d_eff - CNT_W'(1)) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        clk_d = (cnt_d < half);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q  <= DIV_RST;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = clk_q;

endmodule

// File: rtl/div_frec_multi.sv
// Multi-channel frequency divider: NCH independent dividers on one clock,
// each giving a one-cycle tick (clock enable) and a square wave.
//   clkIn   : system clock
//   reset   : synchronous active-high reset, restores DIV_INIT divisors
//   enable  : global count enable
//   chEn    : per-channel count enable
//   clr     : per-channel synchronous phase clear
//   ld      : divisor load strobe
//   ldCh    : channel targeted by the load; indices >= NCH are ignored
//   ldVal   : new divisor value
//   tick    : per-channel one-cycle strobe
//   clkOut  : per-channel square wave
module div_frec_multi
  import div_frec_multi_pkg::*;
#(
  parameter int unsigned              NCH      = 3,
  parameter int unsigned              CNT_W    = CNT_W_DEF,
  parameter logic [NCH*CNT_W-1:0]     DIV_INIT = {CNT_W'(DIV_1KHZ),
                                                  CNT_W'(DIV_10HZ),
                                                  CNT_W'(DIV_1HZ)}
) (
  input  logic                clkIn,
  input  logic                reset,
  input  logic                enable,
  input  logic [NCH-1:0]      chEn,
  input  logic [NCH-1:0]      clr,
  input  logic                ld,
  input  logic [LD_CH_W-1:0]  ldCh,
  input  logic [CNT_W-1:0]    ldVal,
  output logic [NCH-1:0]      tick,
  output logic [NCH-1:0]      clkOut
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic ld_hit;
    logic run;

    assign ld_hit = ld & (ldCh == LD_CH_W'(i));
    assign run    = enable & chEn[i];

    div_frec_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk_i     (clkIn),
      .rst_i     (reset),
      .run_i     (run),
      .clr_i     (clr[i]),
      .ld_i      (ld_hit),
      .ld_val_i  (ldVal),
      .tick_o    (tick[i]),
      .clk_out_o (clkOut[i])
    );
  end

endmodule

// File: tb/tb_div_frec_multi.sv
// Directed testbench for div_frec_multi with NCH=3, CNT_W=8,
// divisors ch0=4, ch1=3, ch2=5. Expected outputs come from a per-channel
// count of enabled edges since the last phase origin.
module tb_div_frec_multi;

  logic       clkIn;
  logic       reset;
  logic       enable;
  logic [2:0] chEn;
  logic [2:0] clr;
  logic       ld;
  logic [2:0] ldCh;
  logic [7:0] ldVal;
  logic [2:0] tick;
  logic [2:0] clkOut;

  int checks;
  int failures;

  int         n  [3];
  int         dv [3];
  logic [2:0] exp_t;
  logic [2:0] exp_c;

  div_frec_multi #(
    .NCH      (3),
    .CNT_W    (8),
    .DIV_INIT ({8'd5, 8'd3, 8'd4})
  ) dut (
    .clkIn  (clkIn),
    .reset  (reset),
    .enable (enable),
    .chEn   (chEn),
    .clr    (clr),
    .ld     (ld),
    .ldCh   (ldCh),
    .ldVal  (ldVal),
    .tick   (tick),
    .clkOut (clkOut)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) n[i] = 0;
    dv[0] = 4; dv[1] = 3; dv[2] = 5;
    exp_t = '0;
    exp_c = '0;
  endtask

  // Applies the inputs the DUT saw on the edge just passed.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (ld && ldCh == i) begin
        dv[i]    = int'(ldVal);
        n[i]     = 0;
        exp_t[i] = 1'b0;
      end else if (clr[i]) begin
        n[i]     = 0;
        exp_t[i] = 1'b0;
      end else if (enable && chEn[i]) begin
        n[i]     = n[i] + 1;
        exp_t[i] = ((n[i] % eff(dv[i])) == 0);
      end else begin
        exp_t[i] = 1'b0;
      end
      exp_c[i] = ((n[i] % eff(dv[i])) < (eff(dv[i]) / 2));
    end
  endtask

  task automatic step();
    @(posedge clkIn);
    #1;
    model_edge();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; chEn = '0; clr = '0;
    ld = 1'b0; ldCh = '0; ldVal = '0;
    repeat (2) @(posedge clkIn);
    #1;
    model_reset();
    checks++;
    if (tick !== 3'b000) begin
      failures++;
      $display("FAIL reset_tick: tick=%b expected 000", tick);
    end
    checks++;
    if (clkOut !== 3'b000) begin
      failures++;
      $display("FAIL reset_clkout: clkOut=%b expected 000", clkOut);
    end
  endtask

  task automatic test_count();
    reset = 1'b0; enable = 1'b1; chEn = 3'b111;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (tick !== exp_t) begin
        failures++;
        $display("FAIL count_tick edge %0d: tick=%b expected %b", k, tick, exp_t);
      end
      checks++;
      if (clkOut !== exp_c) begin
        failures++;
        $display("FAIL count_clkout edge %0d: clkOut=%b expected %b", k, clkOut, exp_c);
      end
    end
  endtask

  task automatic test_pause();
    int first;
    repeat (2) step();          // ch0 counter now at 2
    chEn = 3'b110;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (tick !== exp_t) begin
        failures++;
        $display("FAIL pause_tick cycle %0d: tick=%b expected %b", k, tick, exp_t);
      end
      checks++;
      if (clkOut !== exp_c) begin
        failures++;
        $display("FAIL pause_clkout cycle %0d: clkOut=%b expected %b", k, clkOut, exp_c);
      end
    end
    chEn  = 3'b111;
    first = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (tick !== exp_t) begin
        failures++;
        $display("FAIL resume_tick cycle %0d: tick=%b expected %b", k, tick, exp_t);
      end
      if (tick[0] === 1'b1 && first == 0) first = k;
    end
    checks++;
    if (first !== 2) begin
      failures++;
      $display("FAIL resume_first_tick: ch0 first tick after %0d cycles expected 2", first);
    end
  endtask

  task automatic test_clear();
    int first;
    bit found;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (n[2] % 5 == 3) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL clear_setup: ch2 phase 3 not reached, got %0d expected 3", n[2] % 5);
    end
    clr = 3'b100;
    step();
    clr = 3'b000;
    checks++;
    if (tick[2] !== 1'b0) begin
      failures++;
      $display("FAIL clear_edge_tick: tick[2]=%b expected 0", tick[2]);
    end
    checks++;
    if (clkOut !== exp_c) begin
      failures++;
      $display("FAIL clear_edge_clkout: clkOut=%b expected %b", clkOut, exp_c);
    end
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (tick !== exp_t) begin
        failures++;
        $display("FAIL clear_tick cycle %0d: tick=%b expected %b", k, tick, exp_t);
      end
      if (tick[2] === 1'b1 && first == 0) first = k;
    end
    checks++;
    if (first !== 5) begin
      failures++;
      $display("FAIL clear_period: ch2 first tick after %0d cycles expected 5", first);
    end
  endtask

  task automatic test_load();
    logic [7:0] vals [2];
    vals[0] = 8'd1;
    vals[1] = 8'd0;
    for (int v = 0; v < 2; v++) begin
      ld = 1'b1; ldCh = 3'd1; ldVal = vals[v];
      step();
      ld = 1'b0;
      checks++;
      if (tick !== exp_t) begin
        failures++;
        $display("FAIL load_edge_tick val %0d: tick=%b expected %b", vals[v], tick, exp_t);
      end
      for (int k = 1; k <= 5; k++) begin
        step();
        checks++;
        if (tick[1] !== 1'b1 || clkOut[1] !== 1'b0) begin
          failures++;
          $display("FAIL load_ch1 val %0d cycle %0d: tick1=%b clkOut1=%b expected 1/0",
                   vals[v], k, tick[1], clkOut[1]);
        end
        checks++;
        if (tick !== exp_t || clkOut !== exp_c) begin
          failures++;
          $display("FAIL load_all val %0d cycle %0d: tick=%b clkOut=%b expected %b %b",
                   vals[v], k, tick, clkOut, exp_t, exp_c);
        end
      end
    end
    ld = 1'b1; ldCh = 3'd1; ldVal = 8'd3;
    step();
    ld = 1'b0;
  endtask

  task automatic test_out_of_range();
    ld = 1'b1; ldCh = 3'd5; ldVal = 8'd7;
    for (int k = 1; k <= 18; k++) begin
      if (k == 4) ld = 1'b0;
      step();
      checks++;
      if (tick !== exp_t) begin
        failures++;
        $display("FAIL oor_tick cycle %0d: tick=%b expected %b", k, tick, exp_t);
      end
      checks++;
      if (clkOut !== exp_c) begin
        failures++;
        $display("FAIL oor_clkout cycle %0d: clkOut=%b expected %b", k, clkOut, exp_c);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ticks0;
    ld = 1'b1; ldCh = 3'd0; ldVal = 8'd10;
    step();
    ld = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    @(posedge clkIn);
    #1;
    model_reset();
    reset = 1'b0;
    checks++;
    if (tick !== 3'b000 || clkOut !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_outputs: tick=%b clkOut=%b expected 000 000", tick, clkOut);
    end
    ticks0 = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (tick !== exp_t || clkOut !== exp_c) begin
        failures++;
        $display("FAIL post_reset cycle %0d: tick=%b clkOut=%b expected %b %b",
                 k, tick, clkOut, exp_t, exp_c);
      end
      if (tick[0] === 1'b1) ticks0++;
    end
    checks++;
    if (ticks0 !== 2) begin
      failures++;
      $display("FAIL post_reset_ch0_period: %0d ch0 ticks in 8 cycles expected 2", ticks0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    test_reset();
    test_count();
    test_pause();
    test_clear();
    test_load();
    test_out_of_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
